// File: rtl/plic_target.sv
// Single-target PLIC slice: priority arbiter, claim/complete FSM and completion pulses to gateways.
// Optional threshold register enabled by defining PLIC_TARGET_THRESHOLD_EN.
module plic_target #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_req,
  output logic [NUM_SRC-1:0] int_end,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic               irq,
  input  logic               claim_req,
  output logic               claim_vld,
  output logic [2:0]         claim_id,
  input  logic               complete_req,
  input  logic [2:0]         complete_id
);

  typedef enum logic {StIdle, StClaimed} state_e;

  state_e             state_q, state_d;
  logic [2:0]         in_service_q, in_service_d;
  logic [2:0]         best_id_q, best_id_d;
  logic [PRIO_W-1:0]  best_prio;
  logic               irq_q;
  logic               claim_vld_q, claim_vld_d;
  logic [2:0]         claim_id_q, claim_id_d;
  logic [NUM_SRC-1:0] int_end_q, int_end_d;

  logic [PRIO_W-1:0]  prio_q [NUM_SRC-1:1];
  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  threshold;

  // Source 0 is never a candidate, so its enable bit and request level are don't-cares.
  logic unused_bits;
  assign unused_bits = ^{cfg_wdata, int_req[0], enable_q[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
      enable_q <= '0;
    end else if (cfg_we) begin
      for (int i = 1; i < NUM_SRC; i++) begin
        if (cfg_addr == 4'(i)) begin
          prio_q[i] <= cfg_wdata[PRIO_W-1:0];
        end
      end
      if (cfg_addr == 4'd8) begin
        enable_q <= cfg_wdata[NUM_SRC-1:0];
      end
    end
  end

`ifdef PLIC_TARGET_THRESHOLD_EN
  logic [PRIO_W-1:0] threshold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      threshold_q <= '0;
    end else if (cfg_we && (cfg_addr == 4'd0)) begin
      threshold_q <= cfg_wdata[PRIO_W-1:0];
    end
  end

  assign threshold = threshold_q;
`else
  assign threshold = '0;
`endif

  // Ascending scan with strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    best_id_d = '0;
    best_prio = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (int_req[i] && enable_q[i] && (prio_q[i] > threshold) &&
          (in_service_q != 3'(i)) && ((best_id_d == '0) || (prio_q[i] > best_prio))) begin
        best_id_d = 3'(i);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    claim_vld_d  = 1'b0;
    claim_id_d   = '0;
    int_end_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (claim_req) begin
          claim_vld_d = 1'b1;
          claim_id_d  = best_id_q;
          if (best_id_q != '0) begin
            state_d      = StClaimed;
            in_service_d = best_id_q;
          end
        end
      end
      StClaimed: begin
        // No nesting: a claim while busy always answers with ID 0.
        if (claim_req) begin
          claim_vld_d = 1'b1;
        end
        if (complete_req && (complete_id == in_service_q)) begin
          int_end_d    = NUM_SRC'(1) << in_service_q;
          state_d      = StIdle;
          in_service_d = '0;
        end
      end
      default: begin
        state_d      = StIdle;
        in_service_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      in_service_q <= '0;
      best_id_q    <= '0;
      irq_q        <= 1'b0;
      claim_vld_q  <= 1'b0;
      claim_id_q   <= '0;
      int_end_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_service_q <= in_service_d;
      best_id_q    <= best_id_d;
      irq_q        <= (best_id_q != '0) && (state_q == StIdle);
      claim_vld_q  <= claim_vld_d;
      claim_id_q   <= claim_id_d;
      int_end_q    <= int_end_d;
    end
  end

  assign irq       = irq_q;
  assign claim_vld = claim_vld_q;
  assign claim_id  = claim_id_q;
  assign int_end   = int_end_q;

endmodule

// File: tb/tb_plic_target.sv
// Self-checking bench for plic_target: directed scenarios plus randomized configs
// checked against an event-level model of the arbitration and claim/complete rules.
module tb_plic_target;
  localparam int NS = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] int_req;
  logic [NS-1:0] int_end;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic          irq;
  logic          claim_req;
  logic          claim_vld;
  logic [2:0]    claim_id;
  logic          complete_req;
  logic [2:0]    complete_id;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int         m_prio [NS];
  int         m_thr;
  logic [7:0] m_en;
  logic [7:0] m_req;
  int         m_in_service;

  plic_target #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .int_end      (int_end),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .irq          (irq),
    .claim_req    (claim_req),
    .claim_vld    (claim_vld),
    .claim_id     (claim_id),
    .complete_req (complete_req),
    .complete_id  (complete_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Highest priority level first, then lowest ID within that level.
  function automatic int model_best();
    for (int p = (1 << PW) - 1; p > m_thr; p--) begin
      for (int i = 1; i < NS; i++) begin
        if (m_req[i] && m_en[i] && (m_prio[i] == p) && (i != m_in_service)) return i;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_prio[i] = 0;
    m_thr        = 0;
    m_en         = '0;
    m_in_service = 0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cfg_we       = 1'b0;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    ticks(2);
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = 8'(data);
    tick();
    cfg_we = 1'b0;
    if (addr == 0) begin
`ifdef PLIC_TARGET_THRESHOLD_EN
      m_thr = data & ((1 << PW) - 1);
`endif
    end else if (addr < NS) begin
      m_prio[addr] = data & ((1 << PW) - 1);
    end else if (addr == 8) begin
      m_en = 8'(data);
    end
  endtask

  task automatic set_req(input logic [7:0] v);
    int_req = v;
    m_req   = v;
  endtask

  task automatic claim(output logic v, output logic [2:0] id, output int exp);
    exp       = (m_in_service == 0) ? model_best() : 0;
    claim_req = 1'b1;
    tick();
    v         = claim_vld;
    id        = claim_id;
    claim_req = 1'b0;
    if (exp != 0) m_in_service = exp;
  endtask

  task automatic complete(input int id, output logic [7:0] e1, output logic [7:0] e2,
                          output logic [7:0] exp);
    exp          = (m_in_service != 0 && id == m_in_service) ? (8'd1 << id) : 8'd0;
    complete_req = 1'b1;
    complete_id  = 3'(id);
    tick();
    e1           = int_end;
    complete_req = 1'b0;
    tick();
    e2 = int_end;
    if (exp != 0) m_in_service = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(8'hFF);
    ticks(2);
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (claim_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", claim_vld);
    else n_pass++;
    n_total++; if (claim_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", claim_id);
    else n_pass++;
    n_total++; if (int_end !== 8'h00) $display("FAIL reset_end: got %h want 00", int_end);
    else n_pass++;
    set_req(8'h00);
    do_reset();
  endtask

  task automatic test_basic();
    logic v; logic [2:0] id; int exp; logic [7:0] e1, e2, ee;
    do_reset();
    cfg_write(3, 2);
    cfg_write(8, 8'h08);
    set_req(8'h08);
    tick();
    n_total++; if (irq !== 1'b0) $display("FAIL basic_lat1: got %b want 0", irq); else n_pass++;
    tick();
    n_total++; if (irq !== 1'b1) $display("FAIL basic_lat2: got %b want 1", irq); else n_pass++;
    claim(v, id, exp);
    n_total++; if (v !== 1'b1 || id !== 3'(exp))
      $display("FAIL basic_claim: got vld %b id %0d want vld 1 id %0d", v, id, exp);
    else n_pass++;
    tick();
    n_total++; if (claim_vld !== 1'b0) $display("FAIL basic_vld_pulse: got %b want 0", claim_vld);
    else n_pass++;
    tick();
    n_total++; if (irq !== 1'b0) $display("FAIL basic_irq_off: got %b want 0", irq); else n_pass++;
    set_req(8'h00);
    complete(3, e1, e2, ee);
    n_total++; if (e1 !== ee || e2 !== 8'h00)
      $display("FAIL basic_end: got %h,%h want %h,00", e1, e2, ee);
    else n_pass++;
  endtask

  task automatic test_tie();
    logic v; logic [2:0] id; int exp; logic [7:0] e1, e2, ee;
    do_reset();
    cfg_write(2, 5);
    cfg_write(5, 5);
    cfg_write(6, 4);
    cfg_write(8, 8'hFE);
    set_req(8'h64);
    ticks(3);
    claim(v, id, exp);
    n_total++; if (id !== 3'(exp)) $display("FAIL tie_first: got %0d want %0d", id, exp);
    else n_pass++;
    set_req(8'h60);
    complete(2, e1, e2, ee);
    n_total++; if (e1 !== ee) $display("FAIL tie_end: got %h want %h", e1, ee); else n_pass++;
    ticks(3);
    claim(v, id, exp);
    n_total++; if (id !== 3'(exp)) $display("FAIL tie_second: got %0d want %0d", id, exp);
    else n_pass++;
    complete(int'(id), e1, e2, ee);
  endtask

  task automatic test_threshold();
    logic v; logic [2:0] id; int exp; logic [7:0] e1, e2, ee; logic eirq;
    do_reset();
    cfg_write(0, 4);
    cfg_write(1, 4);
    cfg_write(8, 8'h02);
    set_req(8'h02);
    ticks(3);
    eirq = (model_best() != 0);
    n_total++; if (irq !== eirq) $display("FAIL thr_irq: got %b want %b", irq, eirq); else n_pass++;
    claim(v, id, exp);
    n_total++; if (v !== 1'b1 || id !== 3'(exp))
      $display("FAIL thr_claim: got vld %b id %0d want vld 1 id %0d", v, id, exp);
    else n_pass++;
    if (exp != 0) complete(exp, e1, e2, ee);
    cfg_write(1, 5);
    ticks(3);
    eirq = (model_best() != 0);
    n_total++; if (irq !== eirq) $display("FAIL thr_irq_raised: got %b want %b", irq, eirq);
    else n_pass++;
  endtask

  task automatic claim_on_3();
    logic v; logic [2:0] id; int exp;
    do_reset();
    cfg_write(3, 2);
    cfg_write(8, 8'h08);
    set_req(8'h08);
    ticks(3);
    claim(v, id, exp);
    n_total++; if (id !== 3'(exp)) $display("FAIL setup_claim3: got %0d want %0d", id, exp);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    logic v; logic [2:0] id; int exp; logic [7:0] e1, e2, ee;
    claim_on_3();
    complete(4, e1, e2, ee);
    n_total++; if (e1 !== ee || e2 !== 8'h00)
      $display("FAIL mis_end: got %h,%h want %h,00", e1, e2, ee);
    else n_pass++;
    claim(v, id, exp);
    n_total++; if (v !== 1'b1 || id !== 3'(exp))
      $display("FAIL mis_reclaim: got vld %b id %0d want vld 1 id %0d", v, id, exp);
    else n_pass++;
    ticks(2);
    n_total++; if (irq !== 1'b0) $display("FAIL mis_irq: got %b want 0", irq); else n_pass++;
    set_req(8'h00);
    complete(3, e1, e2, ee);
    n_total++; if (e1 !== ee) $display("FAIL mis_final_end: got %h want %h", e1, ee);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic eirq;
    claim_on_3();
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 3'd3;
    tick();
    claim_req    = 1'b0;
    complete_req = 1'b0;
    m_in_service = 0;
    n_total++; if (int_end !== 8'h08 || claim_vld !== 1'b1 || claim_id !== 3'd0)
      $display("FAIL b2b: got end %h vld %b id %0d want end 08 vld 1 id 0",
               int_end, claim_vld, claim_id);
    else n_pass++;
    tick();
    n_total++; if (int_end !== 8'h00) $display("FAIL b2b_pulse: got %h want 00", int_end);
    else n_pass++;
    ticks(3);
    eirq = (model_best() != 0);
    n_total++; if (irq !== eirq) $display("FAIL b2b_idle_irq: got %b want %b", irq, eirq);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    claim_on_3();
    #1 rst = 1'b1;
    complete_req = 1'b1;
    complete_id  = 3'd3;
    #1;
    n_total++; if (irq !== 1'b0 || claim_vld !== 1'b0 || claim_id !== 3'd0 || int_end !== 8'h00)
      $display("FAIL rstmid_now: got irq %b vld %b id %0d end %h want all 0",
               irq, claim_vld, claim_id, int_end);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (int_end !== 8'h00) seen = 1'b1;
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (int_end !== 8'h00) seen = 1'b1;
    end
    complete_req = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL rstmid_end: got pulse %b want 0", seen);
    else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_random();
    logic v; logic [2:0] id; int exp, exp2, wrong; logic [7:0] e1, e2, ee; logic eirq;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int a = 1; a < NS; a++) cfg_write(a, int'($urandom_range(0, 255)));
      cfg_write(0, int'($urandom_range(0, 7)));
      cfg_write(8, int'($urandom_range(0, 255)));
      cfg_write(int'($urandom_range(9, 15)), int'($urandom_range(0, 255)));
      set_req(8'($urandom));
      ticks(3);
      eirq = (model_best() != 0);
      n_total++; if (irq !== eirq) $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq, eirq);
      else n_pass++;
      claim(v, id, exp);
      n_total++; if (v !== 1'b1 || id !== 3'(exp))
        $display("FAIL rnd_claim[%0d]: got vld %b id %0d want vld 1 id %0d", it, v, id, exp);
      else n_pass++;
      if (exp != 0) begin
        ticks(2);
        n_total++; if (irq !== 1'b0) $display("FAIL rnd_busy_irq[%0d]: got %b want 0", it, irq);
        else n_pass++;
        wrong = (exp % 7) + 1;
        complete(wrong, e1, e2, ee);
        n_total++; if (e1 !== ee) $display("FAIL rnd_wrong_end[%0d]: got %h want %h", it, e1, ee);
        else n_pass++;
        if (it % 2 == 1) cfg_write(8, 0);
        set_req(m_req & ~(8'd1 << exp));
        complete(exp, e1, e2, ee);
        n_total++; if (e1 !== ee || e2 !== 8'h00)
          $display("FAIL rnd_end[%0d]: got %h,%h want %h,00", it, e1, e2, ee);
        else n_pass++;
        ticks(3);
        claim(v, id, exp2);
        n_total++; if (id !== 3'(exp2))
          $display("FAIL rnd_next[%0d]: got %0d want %0d", it, id, exp2);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    int_req      = '0;
    m_req        = '0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    model_reset();
    test_reset();
    test_basic();
    test_tie();
    test_threshold();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
